// File: rtl/md_pkg.sv
// Shared types for the multiply/divide unit.
//   md_op_t           : 4-bit operation code carried with start.
//   md_state_t        : sequencer state (IDLE / RUN).
//   md_is_multicycle  : true for ops that occupy the unit for several cycles.
// Optional feature macro: MD_UNIT_ACCUM_EN (adds MADD/MADDU/MSUB/MSUBU).
package md_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_SWAP  = 4'd7,
    MD_MADD  = 4'd8,
    MD_MADDU = 4'd9,
    MD_MSUB  = 4'd10,
    MD_MSUBU = 4'd11
  } md_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_t;

  function automatic logic md_is_multicycle(md_op_t op);
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: return 1'b1;
`ifdef MD_UNIT_ACCUM_EN
      MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/md_divider.sv
// Combinational signed/unsigned divider.
//   dividend, divisor : WIDTH-bit operands
//   is_signed         : 1 = two's complement division, 0 = unsigned
//   quotient          : truncated toward zero
//   remainder         : takes the sign of the dividend
//   div_zero          : divisor is zero (quotient/remainder are then 0 and
//                       must not be committed by the caller)
// MIN_INT / -1 yields quotient MIN_INT, remainder 0.
module md_divider #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] uq;
  logic [WIDTH-1:0] ur;

  always_comb begin
    neg_a    = is_signed & dividend[WIDTH-1];
    neg_b    = is_signed & divisor[WIDTH-1];
    mag_a    = neg_a ? (~dividend + 1'b1) : dividend;
    mag_b    = neg_b ? (~divisor + 1'b1) : divisor;
    div_zero = (divisor == '0);
    uq       = '0;
    ur       = '0;
    // Guarding the divide keeps x/0 out of the datapath entirely.
    if (!div_zero) begin
      uq = mag_a / mag_b;
      ur = mag_a % mag_b;
    end
    quotient  = (neg_a ^ neg_b) ? (~uq + 1'b1) : uq;
    remainder = neg_a ? (~ur + 1'b1) : ur;
    // The only signed overflow case; pinned explicitly rather than relying
    // on magnitude wrap-around.
    if (is_signed && (dividend == MIN_INT) && (divisor == '1)) begin
      quotient  = MIN_INT;
      remainder = '0;
    end
  end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit with architectural HI/LO registers (E stage).
//   clk, reset       : clock, synchronous active-high reset
//   start, op        : one-cycle request and its md_op_t code
//   rs_data, rt_data : forwarded operands A and B
//   busy             : multi-cycle op in flight; D stage stalls on busy|start
//   done             : one-cycle pulse after HI/LO take a multi-cycle result
//   hi, lo           : architectural HI/LO registers
// Handshake: start is accepted only while busy=0; a start seen while busy=1
// is dropped with no side effect. Single-cycle ops (MTHI/MTLO/SWAP) update
// HI/LO at the accepting edge and raise neither busy nor done.
// Optional feature macro: MD_UNIT_ACCUM_EN (multiply-accumulate into HI/LO).
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  md_op_t           op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  md_state_t        state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  md_op_t           op_q;

  // Multiplier: operands extended to 2*WIDTH so one unsigned multiply gives
  // the correct low 2*WIDTH bits for both signed and unsigned forms.
  logic               mul_signed;
  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] mul_result;

  always_comb begin
    mul_signed = (op_q == MD_MULT) || (op_q == MD_MADD) || (op_q == MD_MSUB);
    a_ext      = mul_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    b_ext      = mul_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    product    = a_ext * b_ext;
`ifdef MD_UNIT_ACCUM_EN
    // Accumulates against HI/LO as they stand at the completion edge.
    case (op_q)
      MD_MADD, MD_MADDU: mul_result = {hi, lo} + product;
      MD_MSUB, MD_MSUBU: mul_result = {hi, lo} - product;
      default:           mul_result = product;
    endcase
`else
    mul_result = product;
`endif
  end

  logic             is_div;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;

  assign is_div = (op_q == MD_DIV) || (op_q == MD_DIVU);

  md_divider #(.WIDTH(WIDTH)) u_divider (
    .dividend  (a_q),
    .divisor   (b_q),
    .is_signed (op_q == MD_DIV),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= MD_NONE;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (md_is_multicycle(op)) begin
              a_q   <= rs_data;
              b_q   <= rt_data;
              op_q  <= op;
              cnt   <= ((op == MD_DIV) || (op == MD_DIVU)) ? CW'(DIV_CYCLES)
                                                           : CW'(MULT_CYCLES);
              busy  <= 1'b1;
              state <= ST_RUN;
            end else begin
              case (op)
                MD_MTHI: hi <= rs_data;
                MD_MTLO: lo <= rs_data;
                MD_SWAP: begin
                  hi <= lo;
                  lo <= hi;
                end
                default: ;
              endcase
            end
          end
        end
        ST_RUN: begin
          if (cnt == CW'(1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_IDLE;
            cnt   <= '0;
            if (is_div) begin
              // Divide by zero still takes the full latency but leaves HI/LO.
              if (!div_zero) begin
                hi <= remainder;
                lo <= quotient;
              end
            end else begin
              {hi, lo} <= mul_result;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Testbench for md_unit (default parameters: WIDTH=32, MULT 5, DIV 10).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_md_unit;
  import md_pkg::*;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  // clock / reset
  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  md_op_t       op;
  logic [W-1:0] rs_data;
  logic [W-1:0] rt_data;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  always #5 clk = ~clk;

  md_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  // scoreboard
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] m_hilo;
  int errors = 0;
  int checks = 0;

  // driver tasks (caller is positioned on a falling edge)
  task automatic drive_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start   = 1'b1;
    op      = md_op_t'(o);
    rs_data = a;
    rt_data = b;
    @(negedge clk);
    start   = 1'b0;
    op      = MD_NONE;
    rs_data = '0;
    rt_data = '0;
  endtask

  task automatic wait_idle(output int cyc, output bit early_done);
    cyc = 0;
    early_done = 1'b0;
    while (busy === 1'b1 && cyc < 200) begin
      if (done !== 1'b0) early_done = 1'b1;
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    logic [2*W-1:0] got;
    reset = 1'b1; start = 1'b0; op = MD_NONE; rs_data = '0; rt_data = '0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    got = {hi, lo};
    checks++; if (got !== '0) begin errors++; $display("FAIL reset_hilo: got %h want 0", got); end
    // reset must win over a simultaneous start
    drive_op(MD_MTHI, 32'h1234_5678, '0);
    checks++; if (hi !== '0) begin errors++; $display("FAIL reset_wins_start: hi got %h want 0", hi); end
    reset = 1'b0;
    m_hilo = '0;
    @(negedge clk);
  endtask

  task automatic test_mult;
    int cyc; bit early; logic [2*W-1:0] exp;
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFF1});
    drive_op(MD_MULT, 32'hFFFF_FFFD, 32'd5);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mult_busy_rise: got %b want 1", busy); end
    wait_idle(cyc, early);
    checks++; if (cyc !== MC) begin errors++; $display("FAIL mult_busy_cycles: got %0d want %0d", cyc, MC); end
    checks++; if (early) begin errors++; $display("FAIL mult_done_early: got 1 want 0"); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL mult_done: got %b want 1", done); end
    exp = exp_q.pop_front(); m_hilo = exp;
    checks++; if ({hi, lo} !== exp) begin errors++; $display("FAIL mult_result: got %h want %h", {hi, lo}, exp); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mult_done_once: got %b want 0", done); end
  endtask

  // three divides issued back to back, each in the first idle cycle
  task automatic test_div;
    logic [3:0]   ops[3] = '{MD_DIVU, MD_DIV, MD_DIV};
    logic [W-1:0] as[3]  = '{32'd100, 32'hFFFF_FFF9, 32'h8000_0000};
    logic [W-1:0] bs[3]  = '{32'd7, 32'd2, 32'hFFFF_FFFF};
    logic [W-1:0] eh[3]  = '{32'd2, 32'hFFFF_FFFF, 32'd0};
    logic [W-1:0] el[3]  = '{32'd14, 32'hFFFF_FFFD, 32'h8000_0000};
    int cyc; bit early; logic [2*W-1:0] exp;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({eh[i], el[i]});
      drive_op(ops[i], as[i], bs[i]);
      checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL div%0d_accept: busy/done got %b%b want 10", i, busy, done); end
      wait_idle(cyc, early);
      checks++; if (cyc !== DC) begin errors++; $display("FAIL div%0d_busy_cycles: got %0d want %0d", i, cyc, DC); end
      checks++; if (done !== 1'b1 || early) begin errors++; $display("FAIL div%0d_done: got %b early %b want 1/0", i, done, early); end
      exp = exp_q.pop_front(); m_hilo = exp;
      checks++; if ({hi, lo} !== exp) begin errors++; $display("FAIL div%0d_result: got %h want %h", i, {hi, lo}, exp); end
    end
    @(negedge clk);
  endtask

  task automatic test_div_zero;
    int cyc; bit early; logic [2*W-1:0] exp;
    drive_op(MD_MTHI, 32'h11, '0);
    drive_op(MD_MTLO, 32'h22, '0);
    m_hilo = {32'h11, 32'h22};
    checks++; if ({hi, lo} !== m_hilo) begin errors++; $display("FAIL mthi_mtlo: got %h want %h", {hi, lo}, m_hilo); end
    exp_q.push_back(m_hilo);
    drive_op(MD_DIV, 32'd9, 32'd0);
    wait_idle(cyc, early);
    checks++; if (cyc !== DC) begin errors++; $display("FAIL divzero_busy_cycles: got %0d want %0d", cyc, DC); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL divzero_done: got %b want 1", done); end
    exp = exp_q.pop_front();
    checks++; if ({hi, lo} !== exp) begin errors++; $display("FAIL divzero_hilo: got %h want %h", {hi, lo}, exp); end
    @(negedge clk);
  endtask

  task automatic test_busy_ignore;
    int cyc; bit early; logic [2*W-1:0] exp;
    exp_q.push_back(64'h0000_0003_0000_0000);
    drive_op(MD_MULTU, 32'h0001_0000, 32'h0003_0000);
    @(negedge clk);
    drive_op(MD_MTHI, 32'hAB, '0); // lands in busy cycle 2: dropped
    wait_idle(cyc, early);
    checks++; if (cyc !== MC - 2) begin errors++; $display("FAIL ignore_remaining_cycles: got %0d want %0d", cyc, MC - 2); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL ignore_done: got %b want 1", done); end
    exp = exp_q.pop_front();
    checks++; if ({hi, lo} !== exp) begin errors++; $display("FAIL ignore_product: got %h want %h", {hi, lo}, exp); end
    @(negedge clk);
    exp_q.push_back({32'hAB, exp[W-1:0]});
    drive_op(MD_MTHI, 32'hAB, '0);
    exp = exp_q.pop_front();
    checks++; if ({hi, lo} !== exp) begin errors++; $display("FAIL mthi_after: got %h want %h", {hi, lo}, exp); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mthi_flags: busy/done got %b%b want 00", busy, done); end
    exp_q.push_back({exp[W-1:0], exp[2*W-1:W]});
    drive_op(MD_SWAP, '0, '0);
    exp = exp_q.pop_front(); m_hilo = exp;
    checks++; if ({hi, lo} !== exp) begin errors++; $display("FAIL swap: got %h want %h", {hi, lo}, exp); end
  endtask

  task automatic test_reset_abort;
    int cyc; bit early; bit saw_done; logic [2*W-1:0] exp;
    drive_op(MD_DIV, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    checks++; if ({hi, lo} !== '0) begin errors++; $display("FAIL abort_hilo: got %h want 0", {hi, lo}); end
    reset = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < DC + 2; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
      @(negedge clk);
    end
    checks++; if (saw_done) begin errors++; $display("FAIL abort_no_done: got activity want none"); end
    exp_q.push_back(64'd6);
    drive_op(MD_MULT, 32'd2, 32'd3);
    wait_idle(cyc, early);
    exp = exp_q.pop_front(); m_hilo = exp;
    checks++; if ({hi, lo} !== exp || cyc !== MC) begin errors++; $display("FAIL abort_then_mult: got %h/%0d want %h/%0d", {hi, lo}, cyc, exp, MC); end
    @(negedge clk);
  endtask

  task automatic test_random;
    int cyc; bit early; logic [2*W-1:0] exp;
    logic [W-1:0] a, b; int sa, sb, q, r; int sel;
    for (int i = 0; i < 12; i++) begin
      sel = $urandom_range(0, 3);
      a = $urandom();
      b = $urandom();
      case (sel)
        0: exp = 64'(longint'($signed(a)) * longint'($signed(b)));
        1: exp = {32'b0, a} * {32'b0, b};
        2: begin
          if (a == 32'h8000_0000) a = 32'd0;
          sb = int'($urandom_range(1, 1000));
          if ($urandom_range(0, 1) == 1) sb = -sb;
          b = W'(sb); sa = $signed(a);
          q = sa / sb; r = sa % sb;
          exp = {32'(r), 32'(q)};
        end
        default: begin
          b = $urandom_range(1, 32'hFFFF);
          exp = {a % b, a / b};
        end
      endcase
      exp_q.push_back(exp);
      drive_op((sel == 0) ? MD_MULT : (sel == 1) ? MD_MULTU : (sel == 2) ? MD_DIV : MD_DIVU, a, b);
      wait_idle(cyc, early);
      exp = exp_q.pop_front(); m_hilo = exp;
      checks++; if ({hi, lo} !== exp || done !== 1'b1 || cyc !== ((sel >= 2) ? DC : MC)) begin
        errors++; $display("FAIL rand%0d_op%0d: got %h done %b cyc %0d want %h", i, sel, {hi, lo}, done, cyc, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_none_ops;
`ifdef MD_UNIT_ACCUM_EN
    logic [3:0] codes[4] = '{4'd0, 4'd12, 4'd13, 4'd15};
`else
    logic [3:0] codes[8] = '{4'd0, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd14, 4'd15};
`endif
    drive_op(MD_MTHI, 32'h55, '0);
    drive_op(MD_MTLO, 32'h66, '0);
    m_hilo = {32'h55, 32'h66};
    foreach (codes[i]) begin
      drive_op(codes[i], 32'd3, 32'd4);
      @(negedge clk);
      checks++; if ({hi, lo} !== m_hilo || busy !== 1'b0 || done !== 1'b0) begin
        errors++; $display("FAIL noop_%0d: got %h busy %b done %b want %h 0 0", codes[i], {hi, lo}, busy, done, m_hilo);
      end
    end
  endtask

`ifdef MD_UNIT_ACCUM_EN
  task automatic test_accum;
    int cyc; bit early; logic [2*W-1:0] exp;
    drive_op(MD_MTLO, 32'd10, '0);
    drive_op(MD_MTHI, 32'd0, '0);
    exp_q.push_back(64'd16);
    drive_op(MD_MADD, 32'd2, 32'd3);
    wait_idle(cyc, early);
    exp = exp_q.pop_front();
    checks++; if ({hi, lo} !== exp || cyc !== MC) begin errors++; $display("FAIL madd: got %h/%0d want %h/%0d", {hi, lo}, cyc, exp, MC); end
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
    drive_op(MD_MSUBU, 32'd4, 32'd5);
    wait_idle(cyc, early);
    exp = exp_q.pop_front(); m_hilo = exp;
    checks++; if ({hi, lo} !== exp || done !== 1'b1) begin errors++; $display("FAIL msubu: got %h done %b want %h", {hi, lo}, done, exp); end
    @(negedge clk);
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_div_zero;
    test_busy_ignore;
    test_reset_abort;
    test_random;
    test_none_ops;
`ifdef MD_UNIT_ACCUM_EN
    test_accum;
`endif
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: got %0d want 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
